// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending dispense stage.
//   - FSM state encodings (kept as plain localparams so older code that
//     compares against raw state values still works).
//   - Coin codes, product price in 0.5-yuan units.
//   - Width of the change-owed register. With VEND_DISPENSE_REFUND_EN
//     defined, the register widens to 3 bits so that change + price
//     (at most 3 + 3 = 6 units) fits.
package vend_pkg;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_MOTOR     = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_DROP = 3'd2;
  localparam logic [ST_W-1:0] ST_EJECT     = 3'd3;
  localparam logic [ST_W-1:0] ST_FAULT     = 3'd4;

  localparam logic [1:0] COIN_05 = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;

  localparam int PRICE_UNITS = 3;

`ifdef VEND_DISPENSE_REFUND_EN
  localparam int CHG_W = 3;
`else
  localparam int CHG_W = 2;
`endif

endpackage

// File: rtl/vend_req_fifo.sv
// vend_req_fifo: small synchronous FIFO holding pending vend requests.
// Each entry is the 2-bit change owed for one purchase.
// Ports:
//   clk, rstn    : clock, synchronous active-low reset
//   push, din    : write one entry (ignored when full and not popping)
//   pop, dout    : dout shows the head entry; pop removes it (ignored when empty)
//   full, empty  : occupancy flags
//   count        : number of entries held (0..DEPTH)
module vend_req_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [1:0]               din,
  input  logic                     pop,
  output logic [1:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rptr];
  // A push while full is still accepted when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: dispense stage behind the vending FSM.
// Queues sell requests, runs the product motor for MOTOR_CYCLES, waits up to
// TIMEOUT_CYCLES for the drop sensor, then pulses the coin ejector once per
// 0.5-yuan change unit. A missing drop raises a jam fault until fault_clr.
// Optional build macro: VEND_DISPENSE_REFUND_EN -- on a drop timeout the
// price is refunded together with the change before entering FAULT.
// Ports:
//   clk, rstn   : clock, synchronous active-low reset
//   sell        : one-cycle vend request
//   change      : change owed (0.5-yuan units), sampled with sell
//   drop_sense  : product-dropped sensor level (synchronised)
//   fault_clr   : one-cycle fault/overflow acknowledge
//   motor_en    : product motor drive
//   coin_eject  : one-cycle pulse per 0.5-yuan coin
//   busy        : activity in progress or requests pending
//   pend_cnt    : entries in the request queue
//   overflow    : sticky, a sell was dropped because the queue was full
//   fault       : jam fault active
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int PEND_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          sell,
  input  logic [1:0]                    change,
  input  logic                          drop_sense,
  input  logic                          fault_clr,
  output logic                          motor_en,
  output logic                          coin_eject,
  output logic                          busy,
  output logic [$clog2(PEND_DEPTH):0]   pend_cnt,
  output logic                          overflow,
  output logic                          fault
);

  localparam int CW = $clog2(PEND_DEPTH) + 1;
  localparam int MW = $clog2(MOTOR_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [ST_W-1:0]  state, state_n;
  logic [CHG_W-1:0] chg_r, chg_n;
  logic [MW-1:0]    mcnt, mcnt_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic             ph, ph_n;          // 0: coin high phase, 1: low phase
  logic             dropped, dropped_n;
`ifdef VEND_DISPENSE_REFUND_EN
  logic             refund, refund_n;  // current eject run ends in FAULT
`endif

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [1:0]       fifo_dout;
  logic [CW-1:0]    pend_nxt;

  assign push = sell && (!full || pop);

  vend_req_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (change),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (pend_cnt)
  );

  // Queue occupancy after this edge, so busy can be registered alongside it.
  always_comb begin
    pend_nxt = pend_cnt;
    if (push && !pop) begin
      pend_nxt = pend_cnt + CW'(1);
    end else if (pop && !push) begin
      pend_nxt = pend_cnt - CW'(1);
    end
  end

  always_comb begin
    state_n   = state;
    chg_n     = chg_r;
    mcnt_n    = mcnt;
    tcnt_n    = tcnt;
    ph_n      = ph;
    dropped_n = dropped;
    pop       = 1'b0;
`ifdef VEND_DISPENSE_REFUND_EN
    refund_n  = refund;
`endif
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          chg_n     = CHG_W'(fifo_dout);
          mcnt_n    = MW'(MOTOR_CYCLES);
          dropped_n = 1'b0;
          state_n   = ST_MOTOR;
        end
      end
      ST_MOTOR: begin
        if (mcnt <= MW'(1)) begin
          // Last motor cycle: a drop sampled now still counts.
          mcnt_n = '0;
          if (dropped || drop_sense) begin
            ph_n    = 1'b0;
            state_n = (chg_r != '0) ? ST_EJECT : ST_IDLE;
          end else begin
            tcnt_n  = TW'(TIMEOUT_CYCLES);
            state_n = ST_WAIT_DROP;
          end
        end else begin
          mcnt_n = mcnt - MW'(1);
          if (drop_sense) begin
            dropped_n = 1'b1;
          end
        end
      end
      ST_WAIT_DROP: begin
        if (drop_sense) begin
          ph_n    = 1'b0;
          state_n = (chg_r != '0) ? ST_EJECT : ST_IDLE;
        end else if (tcnt <= TW'(1)) begin
          tcnt_n = '0;
`ifdef VEND_DISPENSE_REFUND_EN
          chg_n    = chg_r + CHG_W'(PRICE_UNITS);
          refund_n = 1'b1;
          ph_n     = 1'b0;
          state_n  = ST_EJECT;
`else
          state_n  = ST_FAULT;
`endif
        end else begin
          tcnt_n = tcnt - TW'(1);
        end
      end
      ST_EJECT: begin
        if (!ph) begin
          ph_n = 1'b1;
        end else if (chg_r <= CHG_W'(COIN_05)) begin
          chg_n = '0;
`ifdef VEND_DISPENSE_REFUND_EN
          state_n  = refund ? ST_FAULT : ST_IDLE;
          refund_n = 1'b0;
`else
          state_n  = ST_IDLE;
`endif
        end else begin
          chg_n = chg_r - CHG_W'(COIN_05);
          ph_n  = 1'b0;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      chg_r      <= '0;
      mcnt       <= '0;
      tcnt       <= '0;
      ph         <= 1'b0;
      dropped    <= 1'b0;
`ifdef VEND_DISPENSE_REFUND_EN
      refund     <= 1'b0;
`endif
      motor_en   <= 1'b0;
      coin_eject <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      chg_r      <= chg_n;
      mcnt       <= mcnt_n;
      tcnt       <= tcnt_n;
      ph         <= ph_n;
      dropped    <= dropped_n;
`ifdef VEND_DISPENSE_REFUND_EN
      refund     <= refund_n;
`endif
      motor_en   <= (state_n == ST_MOTOR);
      coin_eject <= (state_n == ST_EJECT) && !ph_n;
      fault      <= (state_n == ST_FAULT);
      busy       <= (state_n != ST_IDLE) || (pend_nxt != '0);
      // A rejected sell in the same cycle as an acknowledge keeps the flag.
      if (sell && !push) begin
        overflow <= 1'b1;
      end else if (fault_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: timestamp-based reference model plus
// directed scenarios with hand-computed literal expectations.
module tb_vend_dispense_ctrl;

  localparam int M = 8;
  localparam int T = 64;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sell = 1'b0;
  logic [1:0] change = 2'd0;
  logic       drop_sense = 1'b0;
  logic       fault_clr = 1'b0;
  logic       motor_en, coin_eject, busy, overflow, fault;
  logic [2:0] pend_cnt;

  vend_dispense_ctrl #(
    .MOTOR_CYCLES   (M),
    .TIMEOUT_CYCLES (T),
    .PEND_DEPTH     (D)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sell       (sell),
    .change     (change),
    .drop_sense (drop_sense),
    .fault_clr  (fault_clr),
    .motor_en   (motor_en),
    .coin_eject (coin_eject),
    .busy       (busy),
    .pend_cnt   (pend_cnt),
    .overflow   (overflow),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void cmp(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
    end
  endfunction

  // ---------------- reference model (edge timestamps) ----------------
  int  e = 0;
  bit  m_valid = 0;
  bit  act;       int v_t0;  bit drp;  int v_chg;   // vend in motor/wait
  bit  ej;        int ej_t0; int ej_n; bit ej_fault; // coin run
  bit  flt;
  bit  ovf;
  int  q[$];
  bit  m_idle, m_pop;
  int  m_age;
  bit  x_motor, x_coin, x_busy, x_fault;
  int  x_cnt;

  function automatic void vend_done();
    act = 0;
    if (v_chg > 0) begin
      ej = 1; ej_t0 = e; ej_n = v_chg; ej_fault = 0;
    end
  endfunction

  function automatic void vend_timeout();
    act = 0;
`ifdef VEND_DISPENSE_REFUND_EN
    ej = 1; ej_t0 = e; ej_n = v_chg + 3; ej_fault = 1;
`else
    flt = 1;
`endif
  endfunction

  always @(posedge clk) begin
    e++;
    if (!rstn) begin
      act = 0; ej = 0; flt = 0; ovf = 0; q.delete();
    end else begin
      m_idle = !act && !ej && !flt;
      m_pop  = m_idle && (q.size() > 0);
      if (flt) begin
        if (fault_clr) flt = 0;
      end else if (ej) begin
        if (e - ej_t0 == 2 * ej_n) begin
          ej = 0;
          if (ej_fault) flt = 1;
        end
      end else if (act) begin
        m_age = e - v_t0;
        if (m_age <= M) begin
          if (drop_sense) drp = 1;
          if (m_age == M && drp) vend_done();
        end else if (drop_sense) begin
          vend_done();
        end else if (m_age == M + T) begin
          vend_timeout();
        end
      end
      if (m_pop) begin
        act = 1; v_t0 = e; v_chg = q.pop_front(); drp = 0;
      end
      if (fault_clr) ovf = 0;
      if (sell) begin
        if (q.size() < D) q.push_back(int'(change));
        else ovf = 1;
      end
    end
    x_motor = act && (e - v_t0 < M);
    x_coin  = ej && ((e - ej_t0) % 2 == 0);
    x_fault = flt;
    x_busy  = act || ej || flt || (q.size() != 0);
    x_cnt   = q.size();
    m_valid = 1;
  end

  // ---------------- compare process and trace statistics ----------------
  int ncyc = 0;
  int mot_dut = 0, mot_mdl = 0, coin_dut = 0, coin_mdl = 0;
  int max_dut = 0, max_mdl = 0;
  int rise_cyc = 0, coin_cyc = 0, sell_cyc = 0, clr_cyc = 0;
  int frise_dut = 0, frise_mdl = 0;
  logic pm = 1'b0, pc = 1'b0, pf = 1'b0;
  bit   pxf = 0;

  always @(negedge clk) begin
    ncyc++;
    if (m_valid) begin
      cmp("motor_en",   motor_en,   x_motor);
      cmp("coin_eject", coin_eject, x_coin);
      cmp("busy",       busy,       x_busy);
      cmp("fault",      fault,      x_fault);
      cmp("overflow",   overflow,   ovf);
      cmp("pend_cnt",   pend_cnt,   x_cnt);
      mot_dut  += (motor_en === 1'b1) ? 1 : 0;
      coin_dut += (coin_eject === 1'b1) ? 1 : 0;
      mot_mdl  += x_motor ? 1 : 0;
      coin_mdl += x_coin ? 1 : 0;
      if (int'(pend_cnt) > max_dut) max_dut = int'(pend_cnt);
      if (x_cnt > max_mdl) max_mdl = x_cnt;
      if (motor_en === 1'b1 && pm !== 1'b1) rise_cyc = ncyc;
      if (coin_eject === 1'b1 && pc !== 1'b1) coin_cyc = ncyc;
      if (fault === 1'b1 && pf !== 1'b1) frise_dut = ncyc;
      if (x_fault && !pxf) frise_mdl = ncyc;
      pm = motor_en; pc = coin_eject; pf = fault; pxf = x_fault;
    end
    if (sell) sell_cyc = ncyc;
    if (fault_clr) clr_cyc = ncyc;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_sell(input logic [1:0] c);
    sell = 1'b1; change = c;
    step(1);
    sell = 1'b0; change = 2'd0;
  endtask

  int s, m0, c0, mm0, cm0;
  logic [1:0] chg_tab [5];

  initial begin
    chg_tab[0] = 2'd0; chg_tab[1] = 2'd1; chg_tab[2] = 2'd2;
    chg_tab[3] = 2'd3; chg_tab[4] = 2'd1;

    // Reset
    step(3);
    rstn = 1'b1;
    cmp("rst_pend_cnt", pend_cnt, 0);
    cmp("rst_busy", busy, 0);
    step(2);

    // 1: change 0, drop in third motor cycle
    m0 = mot_dut; c0 = coin_dut; mm0 = mot_mdl;
    do_sell(2'd0);
    s = sell_cyc;
    step(3);
    drop_sense = 1'b1; step(1); drop_sense = 1'b0;
    step(20);
    cmp("s1_motor_cycles", mot_dut - m0, 8);
    cmp("s1_model_motor_cycles", mot_mdl - mm0, 8);
    cmp("s1_motor_start_delay", rise_cyc - s, 2);
    cmp("s1_coins", coin_dut - c0, 0);
    cmp("s1_busy_end", busy, 0);

    // 2: change 1, drop in fifth wait cycle
    c0 = coin_dut; cm0 = coin_mdl;
    do_sell(2'd1);
    s = sell_cyc;
    step(13);
    drop_sense = 1'b1; step(1); drop_sense = 1'b0;
    step(10);
    cmp("s2_coins", coin_dut - c0, 1);
    cmp("s2_model_coins", coin_mdl - cm0, 1);
    cmp("s2_coin_time", coin_cyc - s, 15);

    // 3: five sells back to back, sensor held high
    m0 = mot_dut; c0 = coin_dut;
    drop_sense = 1'b1;
    for (int i = 0; i < 5; i++) do_sell(chg_tab[i]);
    step(70);
    drop_sense = 1'b0;
    step(2);
    cmp("s3_peak_pend", max_dut, 4);
    cmp("s3_model_peak_pend", max_mdl, 4);
    cmp("s3_motor_cycles", mot_dut - m0, 40);
    cmp("s3_coins", coin_dut - c0, 7);
    cmp("s3_overflow", overflow, 0);

    // 3b: six sells back to back overflow the queue
    drop_sense = 1'b1;
    for (int i = 0; i < 6; i++) do_sell(2'd0);
    cmp("ovf_set", overflow, 1);
    cmp("ovf_pend_full", pend_cnt, 4);
    step(60);
    drop_sense = 1'b0;
    fault_clr = 1'b1; step(1); fault_clr = 1'b0;
    cmp("ovf_cleared", overflow, 0);
    step(3);

    // 4: no drop -> fault; queued vend waits, resumes after fault_clr
    c0 = coin_dut;
    do_sell(2'd1);
    s = sell_cyc;
    do_sell(2'd0);
    step(90);
    cmp("s4_fault", fault, 1);
    cmp("s4_pend_held", pend_cnt, 1);
`ifdef VEND_DISPENSE_REFUND_EN
    cmp("s4_fault_time", frise_dut - s, 82);
    cmp("s4_model_fault_time", frise_mdl - s, 82);
    cmp("s4_refund_coins", coin_dut - c0, 4);
`else
    cmp("s4_fault_time", frise_dut - s, 74);
    cmp("s4_model_fault_time", frise_mdl - s, 74);
    cmp("s4_coins", coin_dut - c0, 0);
`endif
    do_sell(2'd0);
    cmp("s4_pend_in_fault", pend_cnt, 2);
    fault_clr = 1'b1; step(1); fault_clr = 1'b0;
    step(2);
    cmp("s4_restart_delay", rise_cyc - clr_cyc, 2);
    cmp("s4_fault_cleared", fault, 0);
    drop_sense = 1'b1;
    step(30);
    drop_sense = 1'b0;
    step(2);

    // 6: reset during eject after the first coin
    c0 = coin_dut;
    drop_sense = 1'b1;
    do_sell(2'd3);
    do_sell(2'd2);
    step(9);
    rstn = 1'b0;
    step(1);
    cmp("r_motor_en", motor_en, 0);
    cmp("r_coin_eject", coin_eject, 0);
    cmp("r_busy", busy, 0);
    cmp("r_fault", fault, 0);
    cmp("r_overflow", overflow, 0);
    cmp("r_pend_cnt", pend_cnt, 0);
    rstn = 1'b1;
    step(20);
    drop_sense = 1'b0;
    cmp("r_coins", coin_dut - c0, 1);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
